cla_seq_adder: RTL and testbench

- Multi-precision add/subtract sequencer. Computes a WIDTH-bit result by time-multiplexing one combinational 4-bit carry-lookahead slice, one nibble per clock, LSB first.
- The nibble carry-out is registered and fed back as the next nibble's carry-in.
- Valid/ready handshakes on both input and output. It sits between an operand source (register file or test stimulus) and a result consumer.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla4_slice.sv | 31 +++
 rtl/cla_seq_adder.sv | 134 +++++++++++++
 tb/tb_cla_seq_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead add/subtract sequencer.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_state_e;

    // Number of slice passes needed for an operand of the given width.
    function automatic int nibs_for(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead slice with flattened carry equations.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W-1:0] g_s;
    logic [NIB_W-1:0] p_s;
    logic [NIB_W-1:0] c_s;

    assign g_s = a & b;
    assign p_s = a | b;

    // Every carry is a two-level function of G, P and ci; no ripple between bits.
    assign c_s[0] = ci;
    assign c_s[1] = g_s[0] | (p_s[0] & ci);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & ci);
    assign co     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);

    assign s = a ^ b ^ c_s;

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract sequencer: one cla4_slice reused per nibble, LSB first,
// with the nibble carry registered between passes and valid/ready on both sides.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             SUB,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             BUSY
);

    localparam int NIBS = nibs_for(WIDTH);
    localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBS - 1);

    cla_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIB_W-1:0] slice_a_s;
    logic [NIB_W-1:0] slice_b_s;
    logic [NIB_W-1:0] slice_s_s;
    logic             slice_co_s;

    assign slice_a_s = a_q[{cnt_q, 2'b00} +: NIB_W];
    assign slice_b_s = b_q[{cnt_q, 2'b00} +: NIB_W];

    cla4_slice u_slice (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .ci (carry_q),
        .s  (slice_s_s),
        .co (slice_co_s)
    );

    // Next-state, datapath update and handshake decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = OP_A;
                    b_d     = SUB ? ~OP_B : OP_B;
                    carry_d = SUB ? 1'b1 : CIN;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[{cnt_q, 2'b00} +: NIB_W] = slice_s_s;
                carry_d = slice_co_s;
                if (cnt_q == LAST_CNT) begin
                    // The last slice sum bit is the result MSB, so overflow is known here.
                    cout_d  = slice_co_s;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s_s[NIB_W-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q != IDLE);
    assign SUM       = sum_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder with hand-computed expected results.
module tb_cla_seq_adder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] OP_A = 16'h0000;
    logic [15:0] OP_B = 16'h0000;
    logic        SUB = 1'b0;
    logic        CIN = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] SUM;
    logic        COUT;
    logic        OVF;
    logic        BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_adder #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .SUB       (SUB),
        .CIN       (CIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .COUT      (COUT),
        .OVF       (OVF),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for IN_READY, presents operands for exactly one accept edge.
    task automatic accept_op(input logic [15:0] a, input logic [15:0] b,
                             input logic sub, input logic cin);
        int w;
        w = 0;
        @(negedge CLK);
        while (!IN_READY && w < 20) begin
            @(negedge CLK);
            w++;
        end
        check_value("in_ready_before_accept", {31'd0, IN_READY}, 32'd1);
        OP_A = a;
        OP_B = b;
        SUB = sub;
        CIN = cin;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check_value("busy_after_accept", {31'd0, BUSY}, 32'd1);
        check_value("in_ready_after_accept", {31'd0, IN_READY}, 32'd0);
    endtask

    // Called right after the accept edge (+#1); counts edges until OUT_VALID.
    task automatic wait_result(input string tag, input logic [15:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
        int n;
        n = 0;
        while (!OUT_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_value({tag, "_latency"}, n, 32'd4);
        check_value({tag, "_sum"}, {16'd0, SUM}, {16'd0, exp_sum});
        check_value({tag, "_cout"}, {31'd0, COUT}, {31'd0, exp_cout});
        check_value({tag, "_ovf"}, {31'd0, OVF}, {31'd0, exp_ovf});
    endtask

    task automatic release_result(input string tag);
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check_value({tag, "_out_valid_low"}, {31'd0, OUT_VALID}, 32'd0);
        check_value({tag, "_in_ready_high"}, {31'd0, IN_READY}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check_value("rst_sum", {16'd0, SUM}, 32'd0);
        check_value("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check_value("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        check_value("rst_busy", {31'd0, BUSY}, 32'd0);
        check_value("rst_cout_ovf", {30'd0, COUT, OVF}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        accept_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result("add_5555", 16'h5555, 1'b0, 1'b0);
        release_result("add_5555");

        accept_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result("add_wrap", 16'h0000, 1'b1, 1'b0);
        release_result("add_wrap");

        accept_op(16'h7FFF, 16'h0000, 1'b0, 1'b1);
        wait_result("add_ovf", 16'h8000, 1'b0, 1'b1);
        release_result("add_ovf");

        accept_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_result("sub_neg", 16'hFFFE, 1'b0, 1'b0);
        release_result("sub_neg");

        accept_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        wait_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
        release_result("sub_ovf");

        // Backpressure: result held while new operands wait on IN_VALID.
        accept_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_result("bp", 16'h3333, 1'b0, 1'b0);
        @(negedge CLK);
        OP_A = 16'hAAAA;
        OP_B = 16'h5555;
        SUB = 1'b0;
        CIN = 1'b0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            check_value("bp_hold_sum", {16'd0, SUM}, 32'h0000_3333);
            check_value("bp_hold_flags", {29'd0, OUT_VALID, COUT, OVF}, 32'd4);
            check_value("bp_hold_in_ready", {31'd0, IN_READY}, 32'd0);
        end
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check_value("bp_release_idle", {30'd0, IN_READY, OUT_VALID}, 32'd2);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check_value("bp_second_accept", {30'd0, BUSY, IN_READY}, 32'd2);
        wait_result("bp_next", 16'hFFFF, 1'b0, 1'b0);
        release_result("bp_next");

        // Reset while the counter is at 2.
        accept_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check_value("midrst_in_ready", {31'd0, IN_READY}, 32'd1);
        check_value("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check_value("midrst_busy", {31'd0, BUSY}, 32'd0);
        check_value("midrst_sum", {16'd0, SUM}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        accept_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_result("after_rst", 16'h0002, 1'b0, 1'b0);
        release_result("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
